edge_pixel_packer: RTL and testbench
====================================

Name: edge_pixel_packer

Overview:
Sits directly downstream of the edge detector top and takes the place of the direct write into the FPGA-to-host FIFO. Each edge-detector output word carries one 8-bit thresholded pixel plus a last-pixel flag. This block packs four pixels into each 32-bit host word, zero-pads and flushes the final partial word of a frame, and checks frame length. It exerts backpressure upstream through a full signal that looks like a FIFO full.

Parameters:
EXPECTED_PIXELS, 304964, edge pixels per frame, i.e. (640-2)*(480-2); used for the length check.
CNT_W, 19, pixel counter width; must satisfy 2^CNT_W > EXPECTED_PIXELS.

Ports:
bus_clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_wren  in  1  edge-detector write strobe (its fpga_to_host wren)
in_din  in  32  edge-detector word: [15:8] pixel, [0] last-pixel flag; [31:16] and [7:1] ignored
ou_full  out  1  backpressure to edge detector (its fpga_to_host full input)
in_fifo_full  in  1  downstream FPGA-to-host FIFO full
ou_fifo_wren  out  1  downstream FIFO write enable
ou_fifo_din  out  32  packed word: pixel k in bits [8k+7:8k], first pixel in k=0
ou_frame_done  out  1  single-cycle pulse when the last word of a frame is written downstream
ou_len_err  out  1  sticky frame-length error
ou_overflow  out  1  sticky flag: write attempted while ou_full=1

Behaviour:
- Reset (asynchronous, any time, including mid-frame): lane=0, assembly word=0, pixel count=0, queue empty, state=IDLE. All outputs read 0.
- Accept condition: in_wren=1 and ou_full=0. A write with ou_full=1 drops the pixel and sets ou_overflow. No other state changes on a dropped write.
- Assembly: an accepted pixel is written to byte lane `lane` of the assembly register, then lane increments modulo 4.
- Word completion occurs when:
  - lane==3 on an accepted pixel, or
  - an accepted pixel has last=1.
  On completion, the word is enqueued with its lanes above the current one forced to 0, tagged with the last flag. Lane and the assembly register then clear.
- Queue: 2 entries, 33 bits each (word + last tag).
  - ou_full = (queue count == 2). Completion therefore always finds a free slot.
  - Enqueue and dequeue in the same cycle leave count unchanged.
- Output path:
  - ou_fifo_wren = (count != 0) && !in_fifo_full.
  - ou_fifo_din = queue head, combinational; it must be 0 when the queue is empty.
  - Latency: completing pixel accepted in cycle N gives ou_fifo_wren in N+1 if in_fifo_full=0. Otherwise the word holds until in_fifo_full drops.
- FSM (2-bit encoding):
  - IDLE: no pixel of the current frame has been accepted yet. First accepted pixel goes to PACK.
  - PACK: accepted pixel with last=1 goes to DRAIN.
  - DRAIN: no new pixels are expected; input is still accepted but belongs to the next frame. When the tagged word is written downstream, pulse ou_frame_done and go to IDLE.
  - Simultaneous case: a next-frame pixel accepted in the same cycle as the tagged write goes to PACK, not IDLE. Its count starts at 1.
- Pixel counter:
  - Increments on every accepted pixel.
  - Checked on the last pixel: counter+1 != EXPECTED_PIXELS sets ou_len_err.
  - Counter exceeding EXPECTED_PIXELS without a last pixel also sets ou_len_err.
  - Counter clears when the last pixel is accepted.
  - ou_len_err and ou_overflow clear only on rst.
- Single-pixel frame (last on the first pixel): word = {24'd0, pix}, tagged last.
- EXPECTED_PIXELS divisible by 4: the final word is full and needs no padding.

Decomposition:
- Shared package edge_pkg holds:
  - PIX_W=8 and PIX_PER_WORD=4
  - input field positions IN_PIX_LSB=8 and IN_LAST_BIT=0
  - FSM state constants IDLE/PACK/DRAIN
  - EXPECTED_PIXELS default, derived from FRAME_WIDTH/FRAME_HEIGHT
- One sub-module: word_queue2, a 2-entry 33-bit FIFO with count, push/pop, and head output.

Test Plan:
- Pixels 0x11,0x22,0x33,0x44 (last=0), downstream not full -> one wren with din=0x44332211, exactly 1 cycle after the 4th accept.
- 6 pixels 0x01..0x06, last on 0x06 -> words 0x04030201 then 0x00000605; ou_frame_done pulses with the second write; ou_len_err=1 because 6 != EXPECTED (bench uses EXPECTED_PIXELS=8 to exercise the error path).
- EXPECTED_PIXELS=8, 8 pixels of 0xFF, last on the 8th, in_fifo_full held high for 20 cycles -> ou_full=1 after the 2nd word; release -> 0xFFFFFFFF written twice, frame_done on the 2nd, ou_len_err=0.
- in_wren with ou_full=1 -> ou_overflow=1; pixel absent from output; queue contents unchanged.
- Assert rst mid-frame after 2 pixels, in_fifo_full=0 -> all outputs 0 immediately; then 4 pixels 0xA0..0xA3 -> din=0xA3A2A1A0, no stale lanes.
- Back-to-back frames with the next-frame pixel accepted on the tagged-word write cycle -> frame_done pulses once, FSM goes to PACK, counter=1.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared constants, types and helpers for the edge pixel packer.
// Frame geometry sets the default pixels-per-frame for the length check.
package edge_pkg;

  localparam int unsigned PIX_W        = 8;
  localparam int unsigned PIX_PER_WORD = 4;
  localparam int unsigned WORD_W       = PIX_W * PIX_PER_WORD;

  localparam int unsigned IN_PIX_LSB  = 8;
  localparam int unsigned IN_LAST_BIT = 0;

  localparam int unsigned FRAME_WIDTH         = 640;
  localparam int unsigned FRAME_HEIGHT        = 480;
  localparam int unsigned EXPECTED_PIXELS_DEF = (FRAME_WIDTH - 2) * (FRAME_HEIGHT - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2
  } edge_state_e;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] word;
  } qword_t;

  // Keeps lanes below `lane`, writes `pix` into `lane`, zeroes everything above.
  function automatic logic [WORD_W-1:0] lane_insert(input logic [WORD_W-1:0] asm_word,
                                                    input logic [1:0]        lane,
                                                    input logic [PIX_W-1:0]  pix);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int k = 0; k < int'(PIX_PER_WORD); k++) begin
      if (k < int'(lane)) begin
        w[k*PIX_W +: PIX_W] = asm_word[k*PIX_W +: PIX_W];
      end else if (k == int'(lane)) begin
        w[k*PIX_W +: PIX_W] = pix;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/word_queue2.sv
// Two-entry FIFO of packed words with last tag; head reads zero when empty.
module word_queue2
  import edge_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  qword_t     data_i,
  input  logic       pop_i,
  output qword_t     head_o,
  output logic [1:0] count_o
);

  qword_t     mem_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q;
  logic       push, pop;

  assign push = push_i && (count_q != 2'd2);
  assign pop  = pop_i && (count_q != 2'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  assign head_o  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/edge_pixel_packer.sv
// Packs four 8-bit edge pixels per 32-bit host word, flushes partial words on
// the last pixel of a frame, and checks frame length.
module edge_pixel_packer
  import edge_pkg::*;
#(
  parameter int unsigned EXPECTED_PIXELS = EXPECTED_PIXELS_DEF,
  parameter int unsigned CNT_W           = 19
) (
  input  logic        bus_clk,
  input  logic        rst,
  input  logic        in_wren,
  input  logic [31:0] in_din,
  output logic        ou_full,
  input  logic        in_fifo_full,
  output logic        ou_fifo_wren,
  output logic [31:0] ou_fifo_din,
  output logic        ou_frame_done,
  output logic        ou_len_err,
  output logic        ou_overflow
);

  edge_state_e       state_q, state_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [1:0]        lane_q, lane_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              len_err_q, len_err_d;
  logic              ovf_q, ovf_d;

  logic [PIX_W-1:0]  pix;
  logic              pix_last;
  logic              accept, complete, tagged_wr;
  logic [WORD_W-1:0] packed_word;
  qword_t            q_head, q_data;
  logic [1:0]        q_count;
  logic              unused_din;

  assign pix        = in_din[IN_PIX_LSB +: PIX_W];
  assign pix_last   = in_din[IN_LAST_BIT];
  assign unused_din = ^{in_din[31:16], in_din[7:1]};

  assign ou_full      = (q_count == 2'd2);
  assign accept       = in_wren && !ou_full;
  assign complete     = accept && ((lane_q == 2'd3) || pix_last);
  assign packed_word  = lane_insert(asm_q, lane_q, pix);
  assign q_data       = '{last: pix_last, word: packed_word};
  assign ou_fifo_wren = (q_count != 2'd0) && !in_fifo_full;
  assign ou_fifo_din  = q_head.word;
  assign tagged_wr    = ou_fifo_wren && q_head.last;
  assign cnt_inc      = cnt_q + CNT_W'(1);

  word_queue2 u_queue (
    .clk_i   (bus_clk),
    .rst_i   (rst),
    .push_i  (complete),
    .data_i  (q_data),
    .pop_i   (ou_fifo_wren),
    .head_o  (q_head),
    .count_o (q_count)
  );

  always_comb begin
    asm_d     = asm_q;
    lane_d    = lane_q;
    cnt_d     = cnt_q;
    len_err_d = len_err_q;
    ovf_d     = ovf_q || (in_wren && ou_full);
    if (accept) begin
      asm_d  = complete ? '0 : packed_word;
      lane_d = complete ? 2'd0 : lane_q + 2'd1;
      if (pix_last) begin
        cnt_d     = '0;
        len_err_d = len_err_q || (cnt_inc != CNT_W'(EXPECTED_PIXELS));
      end else begin
        // Saturate so a runaway frame cannot wrap back under the limit.
        cnt_d     = (cnt_q == '1) ? cnt_q : cnt_inc;
        len_err_d = len_err_q || (cnt_inc > CNT_W'(EXPECTED_PIXELS));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = pix_last ? DRAIN : PACK;
      PACK:  if (accept && pix_last) state_d = DRAIN;
      DRAIN: begin
        // Next-frame pixels may already be in flight when the tagged word leaves.
        if (tagged_wr) begin
          if (accept) state_d = pix_last ? DRAIN : PACK;
          else        state_d = (cnt_q != '0) ? PACK : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      asm_q     <= '0;
      lane_q    <= 2'd0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      asm_q     <= asm_d;
      lane_q    <= lane_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ou_frame_done = tagged_wr;
  assign ou_len_err    = len_err_q;
  assign ou_overflow   = ovf_q;

endmodule

// File: tb/tb_edge_pixel_packer.sv
// Bench for edge_pixel_packer: queue-based reference model checked every cycle
// plus directed scenarios with hand-computed literal expectations.
module tb_edge_pixel_packer;

  localparam int EXP = 8;

  logic        bus_clk = 1'b0;
  logic        rst;
  logic        in_wren;
  logic [31:0] in_din;
  logic        ou_full;
  logic        in_fifo_full;
  logic        ou_fifo_wren;
  logic [31:0] ou_fifo_din;
  logic        ou_frame_done;
  logic        ou_len_err;
  logic        ou_overflow;

  edge_pixel_packer #(
    .EXPECTED_PIXELS (EXP),
    .CNT_W           (5)
  ) dut (
    .bus_clk       (bus_clk),
    .rst           (rst),
    .in_wren       (in_wren),
    .in_din        (in_din),
    .ou_full       (ou_full),
    .in_fifo_full  (in_fifo_full),
    .ou_fifo_wren  (ou_fifo_wren),
    .ou_fifo_din   (ou_fifo_din),
    .ou_frame_done (ou_frame_done),
    .ou_len_err    (ou_len_err),
    .ou_overflow   (ou_overflow)
  );

  always #5 bus_clk = ~bus_clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int fd_cnt = 0;
  bit fin    = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: words waiting downstream, pixels of the open word, length/flags.
  logic [32:0] mq[$];
  logic [7:0]  pq[$];
  int          m_cnt;
  bit          m_err, m_ovf, m_full, m_wr, m_acc;
  logic [31:0] m_word;

  always @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      pq.delete();
      m_cnt = 0;
      m_err = 1'b0;
      m_ovf = 1'b0;
    end else begin
      m_full = (mq.size() == 2);
      m_wr   = (mq.size() != 0) && !in_fifo_full;
      m_acc  = in_wren && !m_full;
      if (in_wren && m_full) m_ovf = 1'b1;
      if (m_wr) void'(mq.pop_front());
      if (m_acc) begin
        pq.push_back(in_din[15:8]);
        m_cnt++;
        if (in_din[0]) begin
          if (m_cnt != EXP) m_err = 1'b1;
          m_cnt = 0;
        end else if (m_cnt > EXP) begin
          m_err = 1'b1;
        end
        if (pq.size() == 4 || in_din[0]) begin
          m_word = '0;
          foreach (pq[k]) m_word = m_word | (32'(pq[k]) << (8 * k));
          mq.push_back({in_din[0], m_word});
          pq.delete();
        end
      end
    end
  end

  always @(negedge bus_clk) begin
    if (!fin) begin
      logic        e_wr;
      logic [32:0] e_head;
      e_head = (mq.size() != 0) ? mq[0] : 33'd0;
      e_wr   = (mq.size() != 0) && !in_fifo_full;
      chk("wren", ou_fifo_wren, e_wr);
      chk("din", ou_fifo_din, e_head[31:0]);
      chk("full", ou_full, mq.size() == 2);
      chk("frame_done", ou_frame_done, e_wr && e_head[32]);
      chk("len_err", ou_len_err, m_err);
      chk("overflow", ou_overflow, m_ovf);
      if (ou_frame_done) fd_cnt++;
    end
  end

  // Presents one pixel for exactly one clock edge.
  task automatic send(input logic [7:0] pix, input logic last);
    in_wren = 1'b1;
    in_din  = {16'hBEEF, pix, 7'h55, last};
    @(posedge bus_clk);
    #1;
    in_wren = 1'b0;
    in_din  = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge bus_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_wren", ou_fifo_wren, 0);
    chk("rst_din", ou_fifo_din, 0);
    chk("rst_full", ou_full, 0);
    chk("rst_len_err", ou_len_err, 0);
    chk("rst_overflow", ou_overflow, 0);
    @(posedge bus_clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, fd1, fd2, fd_base;
    rst          = 1'b1;
    in_wren      = 1'b0;
    in_din       = 32'h0;
    in_fifo_full = 1'b0;
    #3;
    chk("por_wren", ou_fifo_wren, 0);
    chk("por_frame_done", ou_frame_done, 0);
    @(posedge bus_clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Four pixels: one full word, one cycle after the fourth accept.
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    #4;
    chk("t1_no_early_wren", ou_fifo_wren, 0);
    #1;
    send(8'h44, 1'b0);
    #4;
    chk("t1_wren", ou_fifo_wren, 1);
    chk("t1_din", ou_fifo_din, 32'h44332211);
    idle(3);
    do_reset();

    // Six-pixel frame: padded tail word and a length error.
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0);
    send(8'h06, 1'b1);
    #4;
    chk("t2_wren", ou_fifo_wren, 1);
    chk("t2_din", ou_fifo_din, 32'h00000605);
    chk("t2_frame_done", ou_frame_done, 1);
    chk("t2_len_err", ou_len_err, 1);
    idle(3);
    do_reset();

    // Eight-pixel frame against a stalled downstream FIFO, then overflow.
    in_fifo_full = 1'b1;
    for (int i = 0; i < 8; i++) send(8'hFF, i == 7);
    #4;
    chk("t3_full", ou_full, 1);
    chk("t3_wren_held", ou_fifo_wren, 0);
    #1;
    send(8'h77, 1'b0);
    #4;
    chk("t4_overflow", ou_overflow, 1);
    chk("t4_head", ou_fifo_din, 32'hFFFFFFFF);
    #1;
    idle(18);
    in_fifo_full = 1'b0;
    nw  = 0;
    fd1 = 0;
    fd2 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge bus_clk);
      #1;
      if (ou_fifo_wren) begin
        nw++;
        if (nw == 1) fd1 = int'(ou_frame_done);
        if (nw == 2) fd2 = int'(ou_frame_done);
        chk("t3_word", ou_fifo_din, 32'hFFFFFFFF);
      end
    end
    chk("t3_writes", nw, 2);
    chk("t3_fd_first", fd1, 0);
    chk("t3_fd_second", fd2, 1);
    chk("t3_len_err", ou_len_err, 0);
    idle(1);

    // Asynchronous reset mid-frame clears everything, including sticky overflow.
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    chk("t5_ovf_before", ou_overflow, 1);
    do_reset();
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 1'b0);
    #4;
    chk("t5_wren", ou_fifo_wren, 1);
    chk("t5_din", ou_fifo_din, 32'hA3A2A1A0);
    idle(3);
    do_reset();

    // Back-to-back frames: next frame's first pixel lands on the tagged write.
    fd_base = fd_cnt;
    for (int i = 0; i < 16; i++) begin
      send(8'h10 + 8'(i), (i == 7) || (i == 15));
      if (i == 7) begin
        #4;
        chk("t6_fd_on_overlap", ou_frame_done, 1);
        chk("t6_din_tail", ou_fifo_din, 32'h17161514);
        #1;
      end
    end
    idle(4);
    chk("t6_fd_pulses", fd_cnt - fd_base, 2);
    chk("t6_len_err", ou_len_err, 0);

    fin = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
